// File: rtl/pipe_equal_sched_pkg.sv
// Shared definitions for the pipelined equality comparator and its scheduler.
package pipe_equal_sched_pkg;

  // Widest requester ID the tag entry can carry (NREQ up to 16).
  localparam int PE_IDW_MAX = 4;

  // One slot of the scheduler's tag pipeline.
  typedef struct packed {
    logic                  vld;
    logic [PE_IDW_MAX-1:0] id;
  } pe_tag_t;

  // Comparator depth: 3-bit chunk compare, then 6-way AND reduction per stage.
  function automatic int pipe_equal_latency(input int width);
    if (width <= 3)        return 1;
    else if (width <= 18)  return 2;
    else if (width <= 108) return 3;
    else                   return 4;
  endfunction

endpackage

// File: rtl/pipe_equal_sched_if.sv
// Requester/response bundle between compare clients and the shared comparator.
interface pipe_equal_sched_if #(
  parameter int WIDTH = 20,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic                       flush;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic [IDW-1:0]             rsp_id;
  logic                       rsp_eq;
  logic                       busy;

  modport master (
    output flush, req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_eq, busy
  );

  modport slave (
    input  flush, req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_eq, busy
  );
endinterface

// File: rtl/pipe_equal_sched_arb.sv
// Round-robin arbiter: search from ptr with wrap, one grant per cycle.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_win,
  output logic            o_acc
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_win;
  logic           w_any;
  int             w_idx;

  // first requester at or after the pointer, wrapping modulo NREQ
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_any && i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = IDW'(w_idx);
      end
    end
  end

  // flush and reset both suppress the grant outright
  assign o_acc = w_any & ~i_flush & i_rst_n;
  assign o_gnt = o_acc ? (NREQ'(1) << w_win) : '0;
  assign o_win = w_win;

  // pointer moves past the winner only when something is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_ptr <= '0;
    else if (o_acc) r_ptr <= (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;
  end

endmodule

// File: rtl/pipe_equal_sched_cmp.sv
// pipe_equal: fixed-latency equality comparator, no reset and no enable.
module pipe_equal
  import pipe_equal_sched_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             i_clk,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_eq
);

  localparam int CLAT = pipe_equal_latency(WIDTH);
  localparam int NC   = (WIDTH + 2) / 3;
  localparam int PW   = NC * 3;

  logic [PW-1:0]             w_ap, w_bp;
  logic [CLAT-1:0][NC-1:0]   r_lvl;
  logic [CLAT-1:0][NC-1:0]   w_nxt;

  // zero-pad to whole 3-bit chunks; padding always compares equal
  assign w_ap = PW'(i_a);
  assign w_bp = PW'(i_b);

  // stage 0 compares chunks; later stages AND groups of six; spare bits stay 1
  always_comb begin
    w_nxt = '1;
    for (int j = 0; j < NC; j++)
      w_nxt[0][j] = (w_ap[3*j +: 3] == w_bp[3*j +: 3]);
    for (int s = 1; s < CLAT; s++)
      for (int j = 0; j < NC; j++)
        for (int k = 0; k < 6; k++)
          if (6*j + k < NC) w_nxt[s][j] = w_nxt[s][j] & r_lvl[s-1][6*j + k];
  end

  // reduction pipeline registers
  always_ff @(posedge i_clk) begin
    r_lvl <= w_nxt;
  end

  assign o_eq = &r_lvl[CLAT-1];

endmodule

// File: rtl/pipe_equal_sched.sv
// Shares one pipe_equal between NREQ requesters; results return tagged by ID.
module pipe_equal_sched
  import pipe_equal_sched_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int NREQ  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_equal_sched_if.slave   bus
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CLAT = pipe_equal_latency(WIDTH);
  localparam int TLAT = CLAT + 1;

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_win;
  logic             w_acc;
  logic [WIDTH-1:0] r_a, r_b;
  logic             w_cmp;
  pe_tag_t          w_new;
  pe_tag_t [TLAT-1:0] r_tag;
  pe_tag_t          r_rsp;
  logic             r_eq;
  logic             w_busy;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (bus.flush),
    .i_req   (bus.req_valid),
    .o_gnt   (w_gnt),
    .o_win   (w_win),
    .o_acc   (w_acc)
  );

  assign bus.req_ready = w_gnt;

  // operand capture; contents only matter alongside a valid tag
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_a <= bus.req_a[w_win];
      r_b <= bus.req_b[w_win];
    end
  end

  pipe_equal #(.WIDTH(WIDTH)) u_cmp (
    .i_clk (clk),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_eq  (w_cmp)
  );

  // new tag entry; ID held at zero when nothing is accepted
  always_comb begin
    w_new     = '0;
    w_new.vld = w_acc;
    if (w_acc) w_new.id = PE_IDW_MAX'(w_win);
  end

  // tag pipeline tracks the operand register plus comparator stages; flush empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
      r_rsp <= '0;
      r_eq  <= 1'b0;
    end else if (bus.flush) begin
      r_tag <= '0;
      r_rsp <= '0;
      r_eq  <= 1'b0;
    end else begin
      r_tag[0] <= w_new;
      for (int s = 1; s < TLAT; s++) r_tag[s] <= r_tag[s-1];
      r_rsp <= r_tag[TLAT-1];
      r_eq  <= w_cmp & r_tag[TLAT-1].vld;
    end
  end

  // anything still travelling toward the response port
  always_comb begin
    w_busy = r_rsp.vld;
    for (int s = 0; s < TLAT; s++) w_busy = w_busy | r_tag[s].vld;
  end

  assign bus.rsp_valid = r_rsp.vld;
  assign bus.rsp_id    = IDW'(r_rsp.id);
  assign bus.rsp_eq    = r_eq;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_pipe_equal_sched.sv
// Directed and random checks of the shared-comparator scheduler (WIDTH=20, NREQ=4).
module tb_pipe_equal_sched;
  import pipe_equal_sched_pkg::*;

  localparam int WIDTH = 20;
  localparam int NREQ  = 4;
  localparam int TLAT  = pipe_equal_latency(WIDTH) + 1;
  localparam int RD    = TLAT + 1;   // negedges from drive to visible response

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pipe_equal_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

  pipe_equal_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0; idle();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    bus.req_valid = '1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_ready got=%b want=0000", bus.req_ready);
    end
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.busy} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got v=%b id=%0d eq=%b busy=%b want all 0",
                      bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.busy);
    end
    @(negedge clk); @(negedge clk);
    idle(); rst_n = 1'b1;
  endtask

  // requester 2 alone: equal pair, then a pair differing in bit 0, back to back
  task automatic test_single();
    logic ev, eeq;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ev = (c == 5) || (c == 6);
      eeq = (c == 5);
      total++;
      if (bus.rsp_valid !== ev || (ev && (bus.rsp_id !== 2'd2 || bus.rsp_eq !== eeq)) ||
          (!ev && bus.rsp_eq !== 1'b0)) begin
        bad++; $display("FAIL single_rsp c=%0d got v=%b id=%0d eq=%b want v=%b id=2 eq=%b",
                        c, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, ev, eeq);
      end
      if (c == 2) begin
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus.busy); end
      end
      if (c == 7) begin
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", bus.busy); end
      end
      idle();
      if (c == 0) begin
        bus.req_valid = 4'b0100; bus.req_a[2] = 20'h5A5A5; bus.req_b[2] = 20'h5A5A5;
      end else if (c == 1) begin
        bus.req_valid = 4'b0100; bus.req_a[2] = 20'h5A5A5; bus.req_b[2] = 20'h5A5A4;
      end
      #1;
      if (c <= 1) begin
        total++;
        if (bus.req_ready !== 4'b0100) begin
          bad++; $display("FAIL single_ready c=%0d got=%b want=0100", c, bus.req_ready);
        end
      end
    end
  endtask

  // all four valid from reset: grants 0,1,2,3,... and responses in grant order
  task automatic test_round_robin();
    logic [3:0] er;
    logic [1:0] eid;
    logic       ev;
    pulse_reset();
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      ev  = (c >= 5) && (c <= 16);
      eid = 2'((c - 5) % 4);
      total++;
      if (bus.rsp_valid !== ev || (ev && (bus.rsp_id !== eid || bus.rsp_eq !== (eid != 2'd1)))) begin
        bad++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d eq=%b want v=%b id=%0d eq=%b",
                        c, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, ev, eid, (eid != 2'd1));
      end
      idle();
      if (c < 12) begin
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
          bus.req_a[i] = 20'(20'h11111 * (i + 1));
          bus.req_b[i] = bus.req_a[i] ^ ((i == 1) ? 20'h80000 : 20'h0);
        end
      end
      #1;
      er = (c < 12) ? 4'(1 << (c % 4)) : 4'b0000;
      total++;
      if (bus.req_ready !== er) begin
        bad++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, bus.req_ready, er);
      end
    end
  endtask

  // ptr driven to 2, then only 1 and 3 request: 3,1,3,1,...
  task automatic test_two_req();
    logic [3:0] er;
    logic [1:0] eid;
    logic       ev;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      ev  = (c >= 5) && (c <= 11);
      eid = (c % 2 == 1) ? 2'd1 : 2'd3;
      total++;
      if (bus.rsp_valid !== ev || (ev && (bus.rsp_id !== eid || bus.rsp_eq !== 1'b1))) begin
        bad++; $display("FAIL two_rsp c=%0d got v=%b id=%0d eq=%b want v=%b id=%0d eq=1",
                        c, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, ev, eid);
      end
      idle();
      for (int i = 0; i < NREQ; i++) begin bus.req_a[i] = 20'hABCDE; bus.req_b[i] = 20'hABCDE; end
      if (c == 0)      bus.req_valid = 4'b0010;
      else if (c <= 6) bus.req_valid = 4'b1010;
      #1;
      if (c == 0)       er = 4'b0010;
      else if (c > 6)   er = 4'b0000;
      else if (c % 2)   er = 4'b1000;
      else              er = 4'b0010;
      total++;
      if (bus.req_ready !== er) begin
        bad++; $display("FAIL two_ready c=%0d got=%b want=%b", c, bus.req_ready, er);
      end
    end
  endtask

  // two accepted, third held through a flush then withdrawn: nothing returns
  task automatic test_flush();
    logic [3:0] er;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++; $display("FAIL flush_rsp c=%0d got v=%b want v=0", c, bus.rsp_valid);
      end
      if (c == 2 || c == 3) begin
        total++;
        if (bus.busy !== (c == 2)) begin
          bad++; $display("FAIL flush_busy c=%0d got=%b want=%b", c, bus.busy, (c == 2));
        end
      end
      idle();
      if (c <= 2) begin
        bus.req_valid = 4'b0001; bus.req_a[0] = 20'h12345; bus.req_b[0] = 20'h12345;
      end
      if (c == 2) bus.flush = 1'b1;
      #1;
      er = (c <= 1) ? 4'b0001 : 4'b0000;
      total++;
      if (bus.req_ready !== er) begin
        bad++; $display("FAIL flush_ready c=%0d got=%b want=%b", c, bus.req_ready, er);
      end
    end
  endtask

  // async reset with results in flight, then first grant goes to requester 0
  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3) begin
          bad++; $display("FAIL rmid_pre got v=%b id=%0d want v=1 id=3", bus.rsp_valid, bus.rsp_id);
        end
      end
      idle();
      if (c <= 2) begin
        bus.req_valid = 4'b1000; bus.req_a[3] = 20'h00F0F; bus.req_b[3] = 20'h00F0F;
      end
      #1;
      if (c <= 2) begin
        total++;
        if (bus.req_ready !== 4'b1000) begin
          bad++; $display("FAIL rmid_ready c=%0d got=%b want=1000", c, bus.req_ready);
        end
      end
    end
    #1 rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.busy} !== 5'b0 || bus.req_ready !== 4'b0000) begin
      bad++; $display("FAIL rmid_async got v=%b id=%0d eq=%b busy=%b rdy=%b want all 0",
                      bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.busy, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("FAIL rmid_first got=%b want=0001", bus.req_ready);
    end
    @(negedge clk); idle();
    repeat (RD + 1) @(negedge clk);
  endtask

  // random traffic and flushes against a reference model of grants and responses
  task automatic test_random();
    bit         pend [NREQ];
    logic [19:0] ma  [NREQ];
    logic [19:0] mb  [NREQ];
    bit         mv   [RD];
    logic [1:0] mid  [RD];
    bit         meq  [RD];
    int         ptr, win, j;
    bit         fl;
    logic [3:0] er;
    pulse_reset();
    ptr = 0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; ma[i] = '0; mb[i] = '0; end
    for (int s = 0; s < RD; s++) begin mv[s] = 0; mid[s] = '0; meq[s] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== mv[RD-1] ||
          (mv[RD-1] && (bus.rsp_id !== mid[RD-1] || bus.rsp_eq !== meq[RD-1])) ||
          (!mv[RD-1] && bus.rsp_eq !== 1'b0)) begin
        bad++; $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d eq=%b want v=%b id=%0d eq=%b",
                        cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, mv[RD-1], mid[RD-1], meq[RD-1]);
      end
      fl = (cyc < 9980) && ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 0;
        else if (!pend[i] && cyc < 9980 && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          ma[i] = 20'($urandom);
          mb[i] = ($urandom_range(0, 3) == 0) ? (ma[i] ^ (20'h1 << $urandom_range(0, 19))) : ma[i];
        end
        bus.req_valid[i] = pend[i];
        bus.req_a[i]     = ma[i];
        bus.req_b[i]     = mb[i];
      end
      bus.flush = fl;
      win = -1;
      if (!fl)
        for (int k = 0; k < NREQ; k++) begin
          j = (ptr + k) % NREQ;
          if (win < 0 && pend[j]) win = j;
        end
      er = (win >= 0) ? 4'(1 << win) : 4'b0000;
      #1;
      total++;
      if (bus.req_ready !== er) begin
        bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er);
      end
      for (int s = RD-1; s > 0; s--) begin mv[s] = mv[s-1]; mid[s] = mid[s-1]; meq[s] = meq[s-1]; end
      mv[0] = (win >= 0);
      mid[0] = (win >= 0) ? 2'(win) : 2'd0;
      meq[0] = (win >= 0) ? (ma[win] == mb[win]) : 1'b0;
      if (fl) for (int s = 0; s < RD; s++) mv[s] = 0;
      if (win >= 0) begin pend[win] = 0; ptr = (win + 1) % NREQ; end
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rand_drain got busy=%b want=0", bus.busy); end
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_two_req();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
